// File: rtl/checkout_engine.sv
// rtl/checkout_engine.sv - checkout command engine with receipt result port; CHECKOUT_STATS_EN adds stat_customers/stat_grand
module checkout_engine #(
    parameter int          PRICE_W   = 12,
    parameter int          QTY_W     = 8,
    parameter int          SUM_W     = 32,
    parameter int          ID_W      = 16,
    parameter int          PWD_W     = 7,
    parameter int          PASSWORD  = 63,
    parameter int          MAX_TRIES = 3,
    parameter logic [31:0] SEED      = 32'hACE1_0001
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [2:0]         cmd_op,
    input  logic [PRICE_W-1:0] cmd_price,
    input  logic [QTY_W-1:0]   cmd_qty,
    input  logic [ID_W-1:0]    cmd_data,
    output logic [SUM_W-1:0]   sum,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [SUM_W-1:0]   res_total,
    output logic [31:0]        res_receipt,
    output logic [ID_W-1:0]    res_payway,
    output logic [ID_W-1:0]    res_cust,
`ifdef CHECKOUT_STATS_EN
    output logic [15:0]        stat_customers,
    output logic [SUM_W-1:0]   stat_grand,
`endif
    output logic               unlocked,
    output logic               err_pulse,
    output logic               ovf,
    output logic               halted
);
    localparam int P_W   = PRICE_W + QTY_W;
    localparam int EXT_W = ((SUM_W > P_W) ? SUM_W : P_W) + 1;
    localparam int T_W   = $clog2(MAX_TRIES + 1);
    localparam logic [EXT_W-1:0] SUM_MAX_X = {{(EXT_W-SUM_W){1'b0}}, {SUM_W{1'b1}}};

    localparam logic [2:0] OP_PWD  = 3'd0;
    localparam logic [2:0] OP_CUST = 3'd1;
    localparam logic [2:0] OP_ITEM = 3'd2;
    localparam logic [2:0] OP_PLUS = 3'd3;
    localparam logic [2:0] OP_DEL  = 3'd4;
    localparam logic [2:0] OP_CLR  = 3'd5;
    localparam logic [2:0] OP_FIN  = 3'd6;
    localparam logic [2:0] OP_PAY  = 3'd7;

    typedef enum logic [2:0] {S_LOCKED, S_IDLE, S_SHOP, S_PAY, S_RESULT, S_HALT} state_t;

    state_t             r_state, w_state;
    logic [SUM_W-1:0]   r_sum, w_sum, r_total, w_total;
    logic [31:0]        r_receipt, w_receipt, r_lfsr, w_lfsr;
    logic [ID_W-1:0]    r_payway, w_payway, r_cust, w_cust, r_res_cust, w_res_cust;
    logic [P_W-1:0]     r_last, w_last;
    logic [T_W-1:0]     r_tries, w_tries;
    logic               r_res_valid, w_res_valid, r_unlocked, w_unlocked;
    logic               r_err, w_err, r_ovf, w_ovf, r_armed, w_armed, r_del_ok, w_del_ok;
    logic               w_acc;
    logic [P_W-1:0]     w_p;
    logic [EXT_W-1:0]   w_add;
`ifdef CHECKOUT_STATS_EN
    logic [15:0]        r_stat_cust, w_stat_cust;
    logic [SUM_W-1:0]   r_stat_grand, w_stat_grand;
    logic [SUM_W:0]     w_grand_add;
`endif

    assign cmd_ready = (r_state != S_RESULT) && (r_state != S_HALT);
    assign w_acc     = cmd_valid && cmd_ready;
    assign w_p       = P_W'(cmd_price) * P_W'(cmd_qty);
    assign w_add     = EXT_W'(r_sum) + EXT_W'(w_p);

    always_comb begin
        w_state     = r_state;
        w_sum       = r_sum;
        w_total     = r_total;
        w_receipt   = r_receipt;
        w_payway    = r_payway;
        w_cust      = r_cust;
        w_res_cust  = r_res_cust;
        w_last      = r_last;
        w_tries     = r_tries;
        w_res_valid = r_res_valid;
        w_unlocked  = r_unlocked;
        w_err       = 1'b0;
        w_ovf       = r_ovf;
        w_armed     = r_armed;
        w_del_ok    = r_del_ok;
        // Galois form of x^32 + x^22 + x^2 + x + 1
        w_lfsr      = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? 32'h8020_0003 : 32'h0);
`ifdef CHECKOUT_STATS_EN
        w_stat_cust  = r_stat_cust;
        w_stat_grand = r_stat_grand;
        w_grand_add  = {1'b0, r_stat_grand} + {1'b0, r_total};
`endif
        case (r_state)
            S_LOCKED: if (w_acc) begin
                if (cmd_op == OP_PWD && cmd_data[PWD_W-1:0] == PWD_W'(PASSWORD)) begin
                    w_state    = S_IDLE;
                    w_unlocked = 1'b1;
                end else begin
                    w_err = 1'b1;
                    if (cmd_op == OP_PWD) begin
                        w_tries = r_tries + T_W'(1);
                        if (w_tries == T_W'(MAX_TRIES)) w_state = S_HALT;
                    end
                end
            end
            S_IDLE: if (w_acc) begin
                if (cmd_op == OP_CUST) begin
                    w_cust   = cmd_data;
                    w_sum    = '0;
                    w_ovf    = 1'b0;
                    w_armed  = 1'b1;
                    w_last   = '0;
                    w_del_ok = 1'b0;
                    w_state  = S_SHOP;
                end else begin
                    w_err = 1'b1;
                end
            end
            S_SHOP: if (w_acc) begin
                case (cmd_op)
                    OP_ITEM: if (r_armed) begin
                        if (w_add > SUM_MAX_X) begin
                            w_sum = '1;
                            w_ovf = 1'b1;
                        end else begin
                            w_sum = w_add[SUM_W-1:0];
                        end
                        w_last   = w_p;
                        w_armed  = 1'b0;
                        w_del_ok = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                    OP_PLUS: w_armed = 1'b1;
                    OP_DEL: if (r_del_ok) begin
                        w_sum    = (EXT_W'(r_last) >= EXT_W'(r_sum)) ? '0 : (r_sum - SUM_W'(r_last));
                        w_del_ok = 1'b0;
                        w_armed  = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                    OP_CLR: begin
                        w_sum    = '0;
                        w_armed  = 1'b1;
                        w_del_ok = 1'b0;
                        w_ovf    = 1'b0;
                    end
                    OP_FIN: begin
                        w_total = r_sum;
                        w_state = S_PAY;
                    end
                    default: w_err = 1'b1;
                endcase
            end
            S_PAY: if (w_acc) begin
                if (cmd_op == OP_PAY) begin
                    w_payway    = cmd_data;
                    w_receipt   = r_lfsr ^ 32'(r_cust);
                    w_res_cust  = r_cust;
                    w_res_valid = 1'b1;
                    w_state     = S_RESULT;
                end else begin
                    w_err = 1'b1;
                end
            end
            S_RESULT: if (r_res_valid && res_ready) begin
                w_res_valid = 1'b0;
                w_sum       = '0;
                w_state     = S_IDLE;
`ifdef CHECKOUT_STATS_EN
                w_stat_cust  = r_stat_cust + 16'd1;
                w_stat_grand = w_grand_add[SUM_W] ? '1 : w_grand_add[SUM_W-1:0];
`endif
            end
            S_HALT: ;
            default: w_state = S_LOCKED;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_LOCKED;
            r_sum       <= '0;
            r_total     <= '0;
            r_receipt   <= '0;
            r_payway    <= '0;
            r_cust      <= '0;
            r_res_cust  <= '0;
            r_last      <= '0;
            r_tries     <= '0;
            r_res_valid <= 1'b0;
            r_unlocked  <= 1'b0;
            r_err       <= 1'b0;
            r_ovf       <= 1'b0;
            r_armed     <= 1'b0;
            r_del_ok    <= 1'b0;
            r_lfsr      <= SEED;
`ifdef CHECKOUT_STATS_EN
            r_stat_cust  <= '0;
            r_stat_grand <= '0;
`endif
        end else begin
            r_state     <= w_state;
            r_sum       <= w_sum;
            r_total     <= w_total;
            r_receipt   <= w_receipt;
            r_payway    <= w_payway;
            r_cust      <= w_cust;
            r_res_cust  <= w_res_cust;
            r_last      <= w_last;
            r_tries     <= w_tries;
            r_res_valid <= w_res_valid;
            r_unlocked  <= w_unlocked;
            r_err       <= w_err;
            r_ovf       <= w_ovf;
            r_armed     <= w_armed;
            r_del_ok    <= w_del_ok;
            r_lfsr      <= w_lfsr;
`ifdef CHECKOUT_STATS_EN
            r_stat_cust  <= w_stat_cust;
            r_stat_grand <= w_stat_grand;
`endif
        end
    end

    assign sum         = r_sum;
    assign res_valid   = r_res_valid;
    assign res_total   = r_total;
    assign res_receipt = r_receipt;
    assign res_payway  = r_payway;
    assign res_cust    = r_res_cust;
    assign unlocked    = r_unlocked;
    assign err_pulse   = r_err;
    assign ovf         = r_ovf;
    assign halted      = (r_state == S_HALT);
`ifdef CHECKOUT_STATS_EN
    assign stat_customers = r_stat_cust;
    assign stat_grand     = r_stat_grand;
`endif
endmodule

// File: tb/tb_checkout_engine.sv
// tb/tb_checkout_engine.sv - directed plus randomized bench for checkout_engine against a behavioural model
module tb_checkout_engine;
    localparam int          SUM_W = 16;
    localparam longint      SMAX  = 65535;
    localparam logic [31:0] SEED  = 32'hACE1_0001;
    localparam int ST_LOCK = 0, ST_IDLE = 1, ST_SHOP = 2, ST_PAY = 3, ST_RES = 4, ST_HALT = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [2:0]        cmd_op = '0;
    logic [11:0]       cmd_price = '0;
    logic [7:0]        cmd_qty = '0;
    logic [15:0]       cmd_data = '0;
    logic [SUM_W-1:0]  sum;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic [SUM_W-1:0]  res_total;
    logic [31:0]       res_receipt;
    logic [15:0]       res_payway;
    logic [15:0]       res_cust;
    logic              unlocked, err_pulse, ovf, halted;
`ifdef CHECKOUT_STATS_EN
    logic [15:0]       stat_customers;
    logic [SUM_W-1:0]  stat_grand;
    longint            m_scust, m_sgrand;
`endif

    checkout_engine #(.SUM_W(SUM_W)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_price(cmd_price), .cmd_qty(cmd_qty), .cmd_data(cmd_data),
        .sum(sum), .res_valid(res_valid), .res_ready(res_ready), .res_total(res_total),
        .res_receipt(res_receipt), .res_payway(res_payway), .res_cust(res_cust),
`ifdef CHECKOUT_STATS_EN
        .stat_customers(stat_customers), .stat_grand(stat_grand),
`endif
        .unlocked(unlocked), .err_pulse(err_pulse), .ovf(ovf), .halted(halted)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0, n_bad = 0;
    int          m_st, m_tries;
    longint      m_sum, m_last, m_total;
    logic        m_armed, m_delok, m_ovf, m_unl, m_rv, m_err;
    logic [15:0] m_cust, m_rcust, m_payway;
    logic [31:0] m_receipt, m_lfsr;

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
    endfunction

    always @(posedge clk or negedge rst_n)
        if (!rst_n) m_lfsr <= SEED;
        else        m_lfsr <= lfsr_step(m_lfsr);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = ST_LOCK; m_tries = 0; m_sum = 0; m_last = 0; m_total = 0;
        m_armed = 0; m_delok = 0; m_ovf = 0; m_unl = 0; m_rv = 0; m_err = 0;
        m_cust = 0; m_rcust = 0; m_payway = 0; m_receipt = 0;
`ifdef CHECKOUT_STATS_EN
        m_scust = 0; m_sgrand = 0;
`endif
    endtask

    function automatic logic m_ready();
        return (m_st != ST_RES) && (m_st != ST_HALT);
    endfunction

    task automatic model_apply(input int op, input int price, input int qty, input int data);
        longint p;
        p = longint'(price) * longint'(qty);
        m_err = 0;
        case (m_st)
            ST_LOCK:
                if (op == 0 && (data % 128) == 63) begin m_st = ST_IDLE; m_unl = 1; end
                else begin
                    m_err = 1;
                    if (op == 0) begin m_tries++; if (m_tries >= 3) m_st = ST_HALT; end
                end
            ST_IDLE:
                if (op == 1) begin
                    m_cust = 16'(data); m_sum = 0; m_ovf = 0; m_armed = 1;
                    m_last = 0; m_delok = 0; m_st = ST_SHOP;
                end else m_err = 1;
            ST_SHOP:
                case (op)
                    2: if (m_armed) begin
                        if (m_sum + p > SMAX) begin m_sum = SMAX; m_ovf = 1; end
                        else m_sum = m_sum + p;
                        m_last = p; m_armed = 0; m_delok = 1;
                    end else m_err = 1;
                    3: m_armed = 1;
                    4: if (m_delok) begin
                        m_sum = (m_last >= m_sum) ? 0 : m_sum - m_last;
                        m_delok = 0; m_armed = 1;
                    end else m_err = 1;
                    5: begin m_sum = 0; m_armed = 1; m_delok = 0; m_ovf = 0; end
                    6: begin m_total = m_sum; m_st = ST_PAY; end
                    default: m_err = 1;
                endcase
            ST_PAY:
                if (op == 7) begin
                    m_payway = 16'(data); m_receipt = m_lfsr ^ {16'h0, m_cust};
                    m_rcust = m_cust; m_rv = 1; m_st = ST_RES;
                end else m_err = 1;
            default: ;
        endcase
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".sum"}, sum, m_sum);
        chk({tag, ".err"}, err_pulse, m_err);
        chk({tag, ".unl"}, unlocked, m_unl);
        chk({tag, ".halt"}, halted, m_st == ST_HALT);
        chk({tag, ".ovf"}, ovf, m_ovf);
        chk({tag, ".rv"}, res_valid, m_rv);
        chk({tag, ".rdy"}, cmd_ready, m_ready());
        chk({tag, ".total"}, res_total, m_total);
        if (m_rv) begin
            chk({tag, ".rcpt"}, res_receipt, m_receipt);
            chk({tag, ".payway"}, res_payway, m_payway);
            chk({tag, ".rcust"}, res_cust, m_rcust);
        end
    endtask

    // Presents one command for one cycle, called at a negedge.
    task automatic send(input string tag, input int op, input int price, input int qty, input int data);
        cmd_op = 3'(op); cmd_price = 12'(price); cmd_qty = 8'(qty); cmd_data = 16'(data);
        cmd_valid = 1'b1;
        chk({tag, ".rdy_pre"}, cmd_ready, m_ready());
        if (m_ready()) model_apply(op, price, qty, data);
        else m_err = 0;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check_all(tag);
    endtask

    task automatic take_result(input string tag, input int hold);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            m_err = 0;
            check_all({tag, ".hold"});
        end
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        m_err = 0;
        if (m_st == ST_RES) begin
            m_rv = 0; m_sum = 0; m_st = ST_IDLE;
`ifdef CHECKOUT_STATS_EN
            m_scust = (m_scust + 1) % 65536;
            m_sgrand = (m_sgrand + m_total > SMAX) ? SMAX : m_sgrand + m_total;
`endif
        end
        check_all({tag, ".done"});
`ifdef CHECKOUT_STATS_EN
        chk({tag, ".scust"}, stat_customers, m_scust);
        chk({tag, ".sgrand"}, stat_grand, m_sgrand);
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int r, op, price, qty, data;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_all("reset");
        chk("reset.rcpt", res_receipt, 0);
        chk("reset.payway", res_payway, 0);

        send("t1.pwd", 0, 0, 0, 63);
        send("t1.cust", 1, 0, 0, 5);
        send("t1.item1", 2, 10, 3, 0);
        chk("t1.sum30", sum, 30);
        send("t1.plus", 3, 0, 0, 0);
        send("t1.item2", 2, 7, 2, 0);
        chk("t1.sum44", sum, 44);
        send("t1.fin", 6, 0, 0, 0);
        send("t1.pay", 7, 0, 0, 1);
        chk("t1.total44", res_total, 44);
        chk("t1.cust5", res_cust, 5);
        take_result("t1.res", 0);

        send("t3.cust", 1, 0, 0, 2);
        send("t3.item", 2, 100, 2, 0);
        chk("t3.sum200", sum, 200);
        send("t3.del1", 4, 0, 0, 0);
        send("t3.del2", 4, 0, 0, 0);
        chk("t3.err", err_pulse, 1);
        send("t3.item5", 2, 5, 1, 0);
        chk("t3.sum5", sum, 5);
        send("t3.fin", 6, 0, 0, 0);
        send("t3.pay", 7, 0, 0, 9);
        take_result("t3.res", 2);

        send("t4.cust", 1, 0, 0, 3);
        send("t4.item1", 2, 4, 4, 0);
        send("t4.item2", 2, 9, 9, 0);
        chk("t4.err", err_pulse, 1);
        chk("t4.sum16", sum, 16);
        send("t4.clr", 5, 0, 0, 0);
        send("t4.item3", 2, 1, 1, 0);
        chk("t4.sum1", sum, 1);
        send("t4.zero", 3, 0, 0, 0);
        send("t4.qty0", 2, 500, 0, 0);
        send("t4.fin", 6, 0, 0, 0);
        send("t4.pay", 7, 0, 0, 4);
        take_result("t4.res", 1);

        send("t5.cust", 1, 0, 0, 9);
        send("t5.item1", 2, 4095, 255, 0);
        send("t5.plus", 3, 0, 0, 0);
        send("t5.item2", 2, 4095, 255, 0);
        chk("t5.sat", sum, 65535);
        chk("t5.ovf", ovf, 1);
        send("t5.fin", 6, 0, 0, 0);
        send("t5.pay", 7, 0, 0, 2);
        send("t5.ignored", 1, 0, 0, 7);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            @(negedge clk);
            m_err = 0;
            check_all("t5.hold");
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t5.rst_rv", res_valid, 0);
        chk("t5.rst_rdy", cmd_ready, 1);
        chk("t5.rst_unl", unlocked, 0);
        @(negedge clk);
        rst_n = 1'b1;
        send("t5.locked", 1, 0, 0, 3);

        send("rnd.pwd", 0, 0, 0, 63);
        for (int n = 0; n < 300; n++) begin
            if (m_st == ST_RES) begin
                take_result("rnd.res", int'($urandom_range(0, 3)));
            end else begin
                r = int'($urandom_range(0, 11));
                case (r)
                    0, 1, 2, 3: op = 2;
                    4, 5: op = 3;
                    6: op = 4;
                    7: op = 5;
                    8: op = 6;
                    9: op = 7;
                    10: op = 1;
                    default: op = int'($urandom_range(0, 7));
                endcase
                if (m_st == ST_IDLE && $urandom_range(0, 1) == 1) op = 1;
                if (m_st == ST_PAY && $urandom_range(0, 1) == 1) op = 7;
                price = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4095)) : int'($urandom_range(0, 40));
                qty   = int'($urandom_range(0, 12));
                data  = int'($urandom_range(0, 65535));
                send("rnd.cmd", op, price, qty, data);
            end
        end

        do_reset();
        send("t2.pwd10", 0, 0, 0, 10);
        send("t2.pwd11", 0, 0, 0, 11);
        chk("t2.nohalt", halted, 0);
        send("t2.pwd12", 0, 0, 0, 12);
        chk("t2.halted", halted, 1);
        chk("t2.rdy0", cmd_ready, 0);
        send("t2.pwd63", 0, 0, 0, 63);
        chk("t2.still_locked", unlocked, 0);
        do_reset();
        check_all("t2.reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
